ks_data_path_param: RTL and testbench
=====================================

// Module: ks_data_path_param
// PURPOSE
// Parametrised K-and-S datapath: PC, IR, decoder, NREGS-entry register file, 4-op ALU, registered flags.
// Driven by the K-and-S control unit through the existing pc/ir/addr_sel/c_sel/operation/enable strobes.
// Data width, register count and RAM address width are generic.
// All state, including registers and flags, resets asynchronously.
// PARAMETERS
// DATA_W  16  datapath/instruction width; opcode always in [DATA_W-1:DATA_W-8]
// ADDR_W  5   RAM address width = PC width; requires ADDR_W+RA <= DATA_W-8
// NREGS   4   register count, power of 2, >=2; RA=$clog2(NREGS); requires 3*RA <= 8
// PORTS
// clk                  in   1       clock, rising edge
// rst_n                in   1       asynchronous reset, active-low
// branch               in   1       PC load select: 1 = mem_addr, 0 = PC+1
// pc_enable            in   1       PC update strobe
// ir_enable            in   1       IR load strobe (IR <= data_in)
// addr_sel             in   1       ram_addr select: 1 = mem_addr, 0 = PC
// c_sel                in   1       write-back select: 1 = ALU result, 0 = data_in
// operation            in   2       ALU op: 00 OR, 01 ADD, 10 SUB, 11 AND
// write_reg_enable     in   1       register-file write strobe
// flags_reg_enable     in   1       flags register load strobe
// data_in              in   DATA_W  RAM read data
// decoded_instruction  out  enum    decoded_instruction_type from k_and_s_pkg
// zero_op              out  1       registered zero flag
// neg_op               out  1       registered negative flag
// unsigned_overflow    out  1       registered carry/borrow flag
// signed_overflow      out  1       registered two's-complement overflow flag
// ram_addr             out  ADDR_W  RAM address
// data_out             out  DATA_W  RAM write data (= bus_a)
// BEHAVIOUR
// Reset (rst_n=0, async):
//   PC, IR, R[0..NREGS-1] and all four flags go to 0.
//   Outputs: decoded_instruction=I_NOP (IR=0), ram_addr=0, data_out=0.
//   Reset mid-operation discards any pending write or flag update.
// PC:
//   On a pc_enable edge, PC <= branch ? mem_addr : PC+1.
//   Increment wraps from 2^ADDR_W-1 to 0. PC holds when pc_enable=0.
// IR:
//   Loads on an ir_enable edge.
//   Decode is combinational from IR; outputs are valid in the cycle after the load.
// Decode: RA = register-field width; opcode = IR[DATA_W-1:DATA_W-8].
//   Unused register selects and mem_addr default to 0.
//   LOAD 0x81: c = IR[ADDR_W+RA-1:ADDR_W], mem_addr = IR[ADDR_W-1:0].
//   STORE 0x82: a = same register field, mem_addr as LOAD.
//   MOVE 0x91: c = IR[2RA-1:RA], a = b = IR[RA-1:0].
//   ADD 0xA1, SUB 0xA2, AND 0xA3, OR 0xA4: a = IR[RA-1:0], b = IR[2RA-1:RA], c = IR[3RA-1:2RA].
//   Branches (mem_addr = IR[ADDR_W-1:0]): BRANCH 0x01, BZERO 0x02, BNEG 0x03, BOV 0x05, BNOV 0x06, BNNEG 0x0A, BNZERO 0x0B.
//   HALT 0xFF. Any other opcode decodes to I_NOP.
// Register file:
//   Read ports a and b are combinational.
//   Write at the clock edge when write_reg_enable: R[c] <= c_sel ? alu : data_in.
//   Same-cycle read of the register being written returns the old value; there is no bypass.
// ALU: combinational, DATA_W bits, result taken mod 2^DATA_W.
//   ADD: cy = carry-out of a+b.
//   SUB: a-b; cy = borrow, i.e. 1 iff a<b unsigned.
//   ADD/SUB: sov = two's-complement overflow (operand signs vs result sign).
//   AND/OR: cy = sov = 0.
//   All ops: zero = (result==0); neg = result[DATA_W-1].
// Flags:
//   Load all four together on a flags_reg_enable edge; otherwise hold.
//   Flag outputs come directly from the flags register, with 1-cycle latency after the ALU op.
// Simultaneous events:
//   A write and a flag load in the same edge both use the same ALU result.
//   ir_enable and pc_enable in the same edge: IR takes data_in addressed by the old PC.
// TESTING (DATA_W=16, ADDR_W=5, NREGS=4)
// 1. Reset: assert rst_n=0 mid-run -> PC=0, ram_addr=0, flags=0, data_out=0, decoded_instruction=I_NOP, immediately, without waiting for a clock edge.
// 2. Load and add:
//    LOAD R1 with 0x7FFF, LOAD R2 with 0x0001.
//    ADD R3=R1+R2 with flags_reg_enable -> R3=0x8000, neg=1, sov=1, cy=0, zero=0.
// 3. Subtract:
//    SUB 0x0003-0x0005 -> 0xFFFE, cy(borrow)=1, neg=1, sov=0.
//    SUB 0x0005-0x0005 -> 0x0000, zero=1, cy=0.
// 4. Add wrap: ADD 0xFFFF+0x0001 -> 0x0000, zero=1, cy=1, sov=0. AND/OR of the same operands -> cy=0, sov=0.
// 5. PC wrap and branch:
//    Stepping PC from 31 with branch=0 -> 0.
//    BRANCH 0x0107 with branch=1, pc_enable=1 -> PC=7.
//    addr_sel=1 -> ram_addr=7.
// 6. Decode sweep:
//    Every listed opcode gives its enum; 0x00, 0x04 and 0xFE give I_NOP.
//    STORE 0x8245 -> data_out=R2, ram_addr=5 with addr_sel=1.
//    Read of R1 during a write to R1 returns the old value for one cycle.

Source files
------------

// File: rtl/ks_data_path_param.sv
// K-and-S datapath, parametrised on data width, RAM address width and
// register count. Holds PC, IR, register file and flags; the control unit
// sequences it through the enable/select strobes.

package k_and_s_pkg;
    typedef enum logic [3:0] {
        I_NOP, I_LOAD, I_STORE, I_MOVE,
        I_ADD, I_SUB, I_AND, I_OR,
        I_BRANCH, I_BZERO, I_BNEG, I_BOV,
        I_BNOV, I_BNNEG, I_BNZERO, I_HALT
    } decoded_instruction_type;
endpackage

module ks_data_path_param
    import k_and_s_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5,
    parameter int NREGS  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    branch,
    input  logic                    pc_enable,
    input  logic                    ir_enable,
    input  logic                    addr_sel,
    input  logic                    c_sel,
    input  logic [1:0]              operation,
    input  logic                    write_reg_enable,
    input  logic                    flags_reg_enable,
    input  logic [DATA_W-1:0]       data_in,
    output decoded_instruction_type decoded_instruction,
    output logic                    zero_op,
    output logic                    neg_op,
    output logic                    unsigned_overflow,
    output logic                    signed_overflow,
    output logic [ADDR_W-1:0]       ram_addr,
    output logic [DATA_W-1:0]       data_out
);

    localparam int RA = $clog2(NREGS);

    logic [ADDR_W-1:0]             pc;
    logic [DATA_W-1:0]             ir;
    logic [NREGS-1:0][DATA_W-1:0]  regs;
    logic [7:0]                    opcode;
    logic [RA-1:0]                 a_addr, b_addr, c_addr;
    logic [ADDR_W-1:0]             mem_addr;
    logic [DATA_W-1:0]             bus_a, bus_b, bus_c, alu_out;
    logic [DATA_W:0]               sum, diff;
    logic                          alu_cy, alu_sov;

    // IR bits outside the opcode and operand fields are don't-care; fold
    // them into one sink so the whole register reads as consumed.
    logic unused_ir;
    assign unused_ir = ^ir;

    assign opcode = ir[DATA_W-1:DATA_W-8];

    // Combinational decode of the held instruction into enum, selects and address.
    always_comb begin
        decoded_instruction = I_NOP;
        a_addr   = '0;
        b_addr   = '0;
        c_addr   = '0;
        mem_addr = '0;
        case (opcode)
            8'h81: begin
                decoded_instruction = I_LOAD;
                c_addr   = ir[ADDR_W+RA-1:ADDR_W];
                mem_addr = ir[ADDR_W-1:0];
            end
            8'h82: begin
                decoded_instruction = I_STORE;
                a_addr   = ir[ADDR_W+RA-1:ADDR_W];
                mem_addr = ir[ADDR_W-1:0];
            end
            8'h91: begin
                decoded_instruction = I_MOVE;
                c_addr = ir[2*RA-1:RA];
                a_addr = ir[RA-1:0];
                b_addr = ir[RA-1:0];
            end
            8'hA1, 8'hA2, 8'hA3, 8'hA4: begin
                case (opcode[2:0])
                    3'd1:    decoded_instruction = I_ADD;
                    3'd2:    decoded_instruction = I_SUB;
                    3'd3:    decoded_instruction = I_AND;
                    default: decoded_instruction = I_OR;
                endcase
                a_addr = ir[RA-1:0];
                b_addr = ir[2*RA-1:RA];
                c_addr = ir[3*RA-1:2*RA];
            end
            8'h01: begin decoded_instruction = I_BRANCH; mem_addr = ir[ADDR_W-1:0]; end
            8'h02: begin decoded_instruction = I_BZERO;  mem_addr = ir[ADDR_W-1:0]; end
            8'h03: begin decoded_instruction = I_BNEG;   mem_addr = ir[ADDR_W-1:0]; end
            8'h05: begin decoded_instruction = I_BOV;    mem_addr = ir[ADDR_W-1:0]; end
            8'h06: begin decoded_instruction = I_BNOV;   mem_addr = ir[ADDR_W-1:0]; end
            8'h0A: begin decoded_instruction = I_BNNEG;  mem_addr = ir[ADDR_W-1:0]; end
            8'h0B: begin decoded_instruction = I_BNZERO; mem_addr = ir[ADDR_W-1:0]; end
            8'hFF: decoded_instruction = I_HALT;
            default: ;
        endcase
    end

    assign bus_a    = regs[a_addr];
    assign bus_b    = regs[b_addr];
    assign sum      = {1'b0, bus_a} + {1'b0, bus_b};
    // Extra top bit of the zero-extended difference is the borrow (a < b).
    assign diff     = {1'b0, bus_a} - {1'b0, bus_b};
    assign bus_c    = c_sel ? alu_out : data_in;
    assign ram_addr = addr_sel ? mem_addr : pc;
    assign data_out = bus_a;

    // ALU result, carry/borrow and signed overflow for the selected op.
    always_comb begin
        alu_out = bus_a | bus_b;
        alu_cy  = 1'b0;
        alu_sov = 1'b0;
        case (operation)
            2'b01: begin
                alu_out = sum[DATA_W-1:0];
                alu_cy  = sum[DATA_W];
                alu_sov = (bus_a[DATA_W-1] == bus_b[DATA_W-1]) &&
                          (sum[DATA_W-1] != bus_a[DATA_W-1]);
            end
            2'b10: begin
                alu_out = diff[DATA_W-1:0];
                alu_cy  = diff[DATA_W];
                alu_sov = (bus_a[DATA_W-1] != bus_b[DATA_W-1]) &&
                          (diff[DATA_W-1] != bus_a[DATA_W-1]);
            end
            2'b11: alu_out = bus_a & bus_b;
            default: ;
        endcase
    end

    // Program counter: branch target or increment, wrapping at 2^ADDR_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         pc <= '0;
        else if (pc_enable) pc <= branch ? mem_addr : pc + 1'b1;
    end

    // Instruction register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         ir <= '0;
        else if (ir_enable) ir <= data_in;
    end

    // Register file write port; reads above see the pre-edge contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                regs <= '0;
        else if (write_reg_enable) regs[c_addr] <= bus_c;
    end

    // Flags load together from the same ALU result that a write would use.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_op           <= 1'b0;
            neg_op            <= 1'b0;
            unsigned_overflow <= 1'b0;
            signed_overflow   <= 1'b0;
        end else if (flags_reg_enable) begin
            zero_op           <= (alu_out == '0);
            neg_op            <= alu_out[DATA_W-1];
            unsigned_overflow <= alu_cy;
            signed_overflow   <= alu_sov;
        end
    end

endmodule

// File: tb/tb_ks_data_path_param.sv
// Bench for ks_data_path_param: stimulus pushes expected observations into a
// scoreboard queue, a negedge monitor pops and compares them.
module tb_ks_data_path_param;
    import k_and_s_pkg::*;

    localparam int DW = 16;
    localparam int AW = 5;
    localparam int NR = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic branch, pc_enable, ir_enable, addr_sel, c_sel;
    logic [1:0] operation;
    logic write_reg_enable, flags_reg_enable;
    logic [DW-1:0] data_in;
    decoded_instruction_type decoded_instruction;
    logic zero_op, neg_op, unsigned_overflow, signed_overflow;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] data_out;

    ks_data_path_param #(.DATA_W(DW), .ADDR_W(AW), .NREGS(NR)) dut (
        .clk(clk), .rst_n(rst_n), .branch(branch), .pc_enable(pc_enable),
        .ir_enable(ir_enable), .addr_sel(addr_sel), .c_sel(c_sel),
        .operation(operation), .write_reg_enable(write_reg_enable),
        .flags_reg_enable(flags_reg_enable), .data_in(data_in),
        .decoded_instruction(decoded_instruction), .zero_op(zero_op),
        .neg_op(neg_op), .unsigned_overflow(unsigned_overflow),
        .signed_overflow(signed_overflow), .ram_addr(ram_addr),
        .data_out(data_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          sel;   // 0 ram_addr, 1 data_out, 2 flags {z,n,cy,sov}, 3 decode
        logic [31:0] val;
    } exp_t;

    exp_t sbq[$];
    int n_chk = 0;
    int n_fail = 0;

    // Reference model state
    int unsigned rm[NR];
    int unsigned flags_m;
    int unsigned pc_m;
    decoded_instruction_type dec_tab[256];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            0:       return 32'(ram_addr);
            1:       return 32'(data_out);
            2:       return {28'd0, zero_op, neg_op, unsigned_overflow, signed_overflow};
            default: return 32'(decoded_instruction);
        endcase
    endfunction

    // Monitor: everything queued during a cycle is compared at its falling edge.
    always @(negedge clk) begin
        while (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            chk(e.name, observe(e.sel), e.val);
        end
    end

    task automatic expect_v(input string name, input int sel, input logic [31:0] v);
        exp_t e;
        e.name = name; e.sel = sel; e.val = v;
        sbq.push_back(e);
    endtask

    task automatic idle_inputs();
        branch = 0; pc_enable = 0; ir_enable = 0; addr_sel = 0; c_sel = 0;
        operation = 2'b00; write_reg_enable = 0; flags_reg_enable = 0; data_in = '0;
    endtask

    // One cycle: inputs are driven just after the edge and apply to the next one.
    task automatic step();
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    // ALU reference in plain integer arithmetic; flags packed {z,n,cy,sov}.
    task automatic ref_alu(input int op, input int unsigned a, input int unsigned b,
                           output int unsigned res, output int unsigned fl);
        int sa, sb, sr;
        bit cy, sov;
        sa = (a >= 32768) ? int'(a) - 65536 : int'(a);
        sb = (b >= 32768) ? int'(b) - 65536 : int'(b);
        cy = 0; sov = 0; sr = 0;
        case (op)
            1: begin res = (a + b) % 65536; cy = (a + b) > 65535; sr = sa + sb; end
            2: begin res = (a + 65536 - b) % 65536; cy = a < b; sr = sa - sb; end
            3: res = a & b;
            default: res = a | b;
        endcase
        if (op == 1 || op == 2) sov = (sr > 32767) || (sr < -32768);
        fl = {28'd0, res == 0, res >= 32768, cy, sov};
    endtask

    function automatic int opc(input int op);
        case (op)
            1:       return 8'hA1;
            2:       return 8'hA2;
            3:       return 8'hA3;
            default: return 8'hA4;
        endcase
    endfunction

    task automatic load_reg(input int k, input int unsigned val);
        int addr;
        addr = $urandom_range(0, 31);
        step(); ir_enable = 1; data_in = 16'(32'h8100 | (k << 5) | addr);
        step(); write_reg_enable = 1; c_sel = 0; data_in = 16'(val); addr_sel = 1;
        expect_v("load_decode", 3, 32'(I_LOAD));
        expect_v("load_addr", 0, 32'(addr));
        rm[k] = val;
    endtask

    task automatic check_reg(input int k, input int exp = -1);
        int addr;
        addr = $urandom_range(0, 31);
        step(); ir_enable = 1; data_in = 16'(32'h8200 | (k << 5) | addr);
        step(); addr_sel = 1;
        expect_v("store_data", 1, (exp < 0) ? 32'(rm[k]) : 32'(exp));
        expect_v("store_addr", 0, 32'(addr));
        expect_v("store_decode", 3, 32'(I_STORE));
    endtask

    task automatic alu(input int op, input int c, input int a, input int b, input int exp_flags = -1);
        int unsigned res, fl;
        step(); ir_enable = 1; data_in = 16'((opc(op) << 8) | (c << 4) | (b << 2) | a);
        step(); write_reg_enable = 1; c_sel = 1; flags_reg_enable = 1; operation = 2'(op);
        expect_v("alu_decode", 3, 32'(dec_tab[opc(op)]));
        expect_v("alu_bus_a", 1, 32'(rm[a]));
        ref_alu(op, rm[a], rm[b], res, fl);
        rm[c] = res;
        flags_m = fl;
        step();
        expect_v("flags", 2, (exp_flags < 0) ? 32'(flags_m) : 32'(exp_flags));
    endtask

    function automatic int unsigned rand_val();
        case ($urandom_range(0, 5))
            0:       return 0;
            1:       return 16'hFFFF;
            2:       return 16'h7FFF;
            3:       return 16'h8000;
            default: return $urandom & 16'hFFFF;
        endcase
    endfunction

    initial begin
        int ops[18];
        foreach (dec_tab[i]) dec_tab[i] = I_NOP;
        dec_tab[8'h81] = I_LOAD;   dec_tab[8'h82] = I_STORE;  dec_tab[8'h91] = I_MOVE;
        dec_tab[8'hA1] = I_ADD;    dec_tab[8'hA2] = I_SUB;    dec_tab[8'hA3] = I_AND;
        dec_tab[8'hA4] = I_OR;     dec_tab[8'h01] = I_BRANCH; dec_tab[8'h02] = I_BZERO;
        dec_tab[8'h03] = I_BNEG;   dec_tab[8'h05] = I_BOV;    dec_tab[8'h06] = I_BNOV;
        dec_tab[8'h0A] = I_BNNEG;  dec_tab[8'h0B] = I_BNZERO; dec_tab[8'hFF] = I_HALT;
        ops = '{8'h81, 8'h82, 8'h91, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'h01, 8'h02,
                8'h03, 8'h05, 8'h06, 8'h0A, 8'h0B, 8'hFF, 8'h00, 8'h04, 8'hFE};
        foreach (rm[i]) rm[i] = 0;
        flags_m = 0; pc_m = 0;

        // Power-on reset
        idle_inputs();
        rst_n = 0;
        #1;
        chk("por_ram_addr", 32'(ram_addr), 0);
        chk("por_data_out", 32'(data_out), 0);
        chk("por_flags", observe(2), 0);
        chk("por_decode", 32'(decoded_instruction), 32'(I_NOP));
        step(); step(); rst_n = 1;

        // Load and add: 0x7FFF + 1 -> 0x8000, n=1 sov=1
        load_reg(1, 16'h7FFF); load_reg(2, 16'h0001);
        alu(1, 3, 1, 2, 4'b0101); check_reg(3, 16'h8000);

        // Subtract with borrow, then equal operands
        load_reg(1, 16'h0003); load_reg(2, 16'h0005);
        alu(2, 3, 1, 2, 4'b0110); check_reg(3, 16'hFFFE);
        alu(2, 0, 2, 2, 4'b1000); check_reg(0, 16'h0000);

        // Add wrap, then logic ops on the same operands
        load_reg(1, 16'hFFFF); load_reg(2, 16'h0001);
        alu(1, 3, 1, 2, 4'b1010); check_reg(3, 16'h0000);
        alu(3, 3, 1, 2, 4'b0000); check_reg(3, 16'h0001);
        alu(0, 3, 1, 2, 4'b0100); check_reg(3, 16'hFFFF);

        // Randomised ALU traffic against the reference model
        for (int it = 0; it < 40; it++) begin
            int ra, rb, rc, op;
            ra = $urandom_range(0, NR-1); rb = $urandom_range(0, NR-1);
            rc = $urandom_range(0, NR-1); op = $urandom_range(0, 3);
            load_reg(ra, rand_val());
            if (rb != ra) load_reg(rb, rand_val());
            alu(op, rc, ra, rb);
            check_reg(rc);
        end

        // No bypass: MOVE R1,R1 exposes R1 on bus_a while R1 is written
        load_reg(1, 16'h1111);
        step(); ir_enable = 1; data_in = 16'h9105;
        step(); write_reg_enable = 1; c_sel = 0; data_in = 16'h2222;
        expect_v("move_decode", 3, 32'(I_MOVE));
        expect_v("nobypass_old", 1, 32'h1111);
        rm[1] = 16'h2222;
        step();
        expect_v("nobypass_new", 1, 32'h2222);

        // Decode sweep over listed opcodes plus random ones
        foreach (ops[i]) begin
            step(); ir_enable = 1; data_in = 16'((ops[i] << 8) | $urandom_range(0, 255));
            step(); expect_v("decode_sweep", 3, 32'(dec_tab[ops[i]]));
        end
        for (int i = 0; i < 20; i++) begin
            int op;
            op = $urandom_range(0, 255);
            step(); ir_enable = 1; data_in = 16'((op << 8) | $urandom_range(0, 255));
            step(); expect_v("decode_rand", 3, 32'(dec_tab[op]));
        end

        // PC increment through the wrap (PC still 0 here)
        for (int i = 0; i < 33; i++) begin
            step(); pc_enable = 1;
            expect_v("pc_step", 0, 32'(pc_m));
            pc_m = (pc_m + 1) % 32;
        end
        step(); expect_v("pc_after_wrap", 0, 32'(pc_m));

        // Branch to 7
        step(); ir_enable = 1; data_in = 16'h0107;
        step(); pc_enable = 1; branch = 1;
        expect_v("branch_decode", 3, 32'(I_BRANCH));
        pc_m = 7;
        step(); expect_v("branch_pc", 0, 32'd7);
        step(); addr_sel = 1; expect_v("branch_mem_addr", 0, 32'd7);

        // IR load and PC step on the same edge
        step(); ir_enable = 1; pc_enable = 1; data_in = 16'hFF00;
        expect_v("sim_old_pc", 0, 32'(pc_m));
        pc_m = (pc_m + 1) % 32;
        step();
        expect_v("sim_decode", 3, 32'(I_HALT));
        expect_v("sim_new_pc", 0, 32'(pc_m));

        // Reset mid-run with a write and flag load armed
        load_reg(1, 16'h1234); load_reg(2, 16'h2000);
        alu(2, 3, 1, 2, 4'b0110);
        step(); ir_enable = 1; data_in = 16'h8220;
        step(); write_reg_enable = 1; flags_reg_enable = 1; c_sel = 0; data_in = 16'hBEEF;
        #2;
        rst_n = 0;
        #1;
        chk("rst_ram_addr", 32'(ram_addr), 0);
        chk("rst_data_out", 32'(data_out), 0);
        chk("rst_flags", observe(2), 0);
        chk("rst_decode", 32'(decoded_instruction), 32'(I_NOP));
        step(); rst_n = 1;
        foreach (rm[i]) rm[i] = 0;
        flags_m = 0; pc_m = 0;
        expect_v("rst_pc_held", 0, 32'd0);
        expect_v("rst_flags_held", 2, 32'd0);
        check_reg(1, 0);
        check_reg(3, 0);

        // Drain the scoreboard within a bounded number of cycles
        repeat (3) @(negedge clk);
        #1;
        n_chk++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sbq.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
